// File: rtl/link_pkg.sv
// Shared definitions for the inter-FPGA link serializer/deserializer pair.
package link_pkg;

  localparam int unsigned CHANNEL_WORD_WIDTH = 64;
  // Credit counter width, shared with the rx deserializer (covers 1..255 credits).
  localparam int unsigned LINK_CREDIT_WIDTH = 8;

  typedef enum logic {
    LTX_IDLE,
    LTX_SEND
  } link_tx_state_t;

  function automatic int unsigned num_flits(input int unsigned width);
    return CHANNEL_WORD_WIDTH / width;
  endfunction

endpackage

// File: rtl/fifo_wrapper.sv
// Synchronous word FIFO, show-ahead read port (dout valid whenever !empty).
module fifo_wrapper #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  output logic             input_ready,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign input_ready = (count != FULL_COUNT);
  assign empty       = (count == '0);
  assign do_wr       = wr_en && input_ready;
  assign do_rd       = rd_en && !empty;
  assign dout        = mem[rd_ptr];

  // Storage array write.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/link_tx_serializer.sv
// Hub tx word -> narrow link flit serializer with credit-based flow control.
// Optional build macro LINK_PARITY_EN adds a registered per-flit parity output.
module link_tx_serializer
  import link_pkg::*;
#(
  parameter int unsigned LINK_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned MAX_CREDITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [63:0]           din,
  input  logic                  wr_en,
  output logic                  full,
  output logic [LINK_WIDTH-1:0] link_data,
  output logic                  link_valid,
  output logic                  link_sof,
  input  logic                  credit_return,
  output logic                  busy,
  output logic                  overflow_err,
  output logic                  credit_err
`ifdef LINK_PARITY_EN
  ,
  output logic                  link_parity
`endif
);

  localparam int unsigned NUM_FLITS = num_flits(LINK_WIDTH);
  localparam int unsigned IDX_W     = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FLITS - 1);
  localparam logic [LINK_CREDIT_WIDTH-1:0] CREDIT_MAX = LINK_CREDIT_WIDTH'(MAX_CREDITS);
  localparam logic [LINK_CREDIT_WIDTH-1:0] CREDIT_ONE = LINK_CREDIT_WIDTH'(1);

  logic [63:0]                  fifo_dout;
  logic                         fifo_empty;
  logic                         input_ready;
  logic                         launch;
  logic                         credit_ok;
  logic [LINK_CREDIT_WIDTH-1:0] credits;
  link_tx_state_t               state;
  logic [63:0]                  word_reg;
  logic [IDX_W-1:0]             flit_idx;
  logic [IDX_W-1:0]             next_idx;
  logic [LINK_WIDTH-1:0]        first_flit;
  logic [LINK_WIDTH-1:0]        next_flit;

  fifo_wrapper #(
    .WIDTH (CHANNEL_WORD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_in_fifo (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .wr_en       (wr_en),
    .input_ready (input_ready),
    .rd_en       (launch),
    .dout        (fifo_dout),
    .empty       (fifo_empty)
  );

  assign full = !input_ready;
  assign busy = !fifo_empty || (state == LTX_SEND);

  // A new word may start from idle or in the cycle the last flit is on the link,
  // which gives back-to-back words with no bubble.
  assign launch    = !fifo_empty && (credits != '0) &&
                     ((state == LTX_IDLE) || (flit_idx == LAST_IDX));
  assign credit_ok = credit_return && (credits != CREDIT_MAX);

  // Flit 0 comes straight from the FIFO head; later flits are sliced from the held word.
  assign next_idx   = flit_idx + IDX_W'(1);
  assign first_flit = fifo_dout[LINK_WIDTH-1:0];
  assign next_flit  = LINK_WIDTH'(word_reg >> (32'(next_idx) * LINK_WIDTH));

  // Credit counter and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credits      <= CREDIT_MAX;
      credit_err   <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      case ({credit_ok, launch})
        2'b10:   credits <= credits + CREDIT_ONE;
        2'b01:   credits <= credits - CREDIT_ONE;
        default: credits <= credits;
      endcase
      if (credit_return && (credits == CREDIT_MAX)) credit_err   <= 1'b1;
      if (wr_en && !input_ready)                    overflow_err <= 1'b1;
    end
  end

  // Serializer FSM with registered link outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= LTX_IDLE;
      word_reg   <= '0;
      flit_idx   <= '0;
      link_data  <= '0;
      link_valid <= 1'b0;
      link_sof   <= 1'b0;
`ifdef LINK_PARITY_EN
      link_parity <= 1'b0;
`endif
    end else if (launch) begin
      state      <= LTX_SEND;
      word_reg   <= fifo_dout;
      flit_idx   <= '0;
      link_data  <= first_flit;
      link_valid <= 1'b1;
      link_sof   <= 1'b1;
`ifdef LINK_PARITY_EN
      link_parity <= ^first_flit;
`endif
    end else if ((state == LTX_SEND) && (flit_idx != LAST_IDX)) begin
      flit_idx   <= next_idx;
      link_data  <= next_flit;
      link_valid <= 1'b1;
      link_sof   <= 1'b0;
`ifdef LINK_PARITY_EN
      link_parity <= ^next_flit;
`endif
    end else begin
      state      <= LTX_IDLE;
      flit_idx   <= '0;
      link_data  <= '0;
      link_valid <= 1'b0;
      link_sof   <= 1'b0;
`ifdef LINK_PARITY_EN
      link_parity <= 1'b0;
`endif
    end
  end

endmodule
